button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 36 +++
 rtl/button_conditioner_channel.sv | 113 +++++++++++
 rtl/button_conditioner.sv | 80 ++++++++
 tb/tb_button_conditioner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared LockIn UI definitions for the front-panel button conditioner:
// per-key FSM state encoding, default timing constants (for a 50 MHz clock)
// and a helper that sizes the timing counters.
package button_conditioner_pkg;

    // Per-key hold tracker state encoding
    typedef logic [1:0] channel_state_t;

    localparam channel_state_t ST_RELEASED    = 2'd0;
    localparam channel_state_t ST_HELD_DELAY  = 2'd1;
    localparam channel_state_t ST_HELD_REPEAT = 2'd2;

    // Default timing: 10 ms debounce, 500 ms to first repeat, 100 ms repeat rate
    localparam int DEFAULT_DEBOUNCE_CYCLES     = 500000;
    localparam int DEFAULT_REPEAT_DELAY_CYCLES = 25000000;
    localparam int DEFAULT_REPEAT_RATE_CYCLES  = 5000000;

    // Buttons on the LockIn front panel pull to ground when pressed
    localparam bit DEFAULT_BTN_ACTIVE_LOW = 1'b1;

    // Width of a counter that must reach cycles-1; never narrower than one bit
    function automatic int counter_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Larger of two widths, used when one counter serves two timeouts
    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One front-panel key: 2-flop synchronizer, debounce filter that accepts a
// level only after a full run of identical samples, and a hold tracker that
// emits a one-cycle pulse on press plus optional auto-repeat pulses.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES,
    parameter bit BTN_ACTIVE_LOW      = DEFAULT_BTN_ACTIVE_LOW,
    parameter bit REPEAT_EN           = 1'b1
)
(
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int DB_W    = counter_width(DEBOUNCE_CYCLES);
    localparam int DELAY_W = counter_width(REPEAT_DELAY_CYCLES);
    localparam int RATE_W  = counter_width(REPEAT_RATE_CYCLES);
    localparam int RP_W    = max_width(DELAY_W, RATE_W);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_CYCLES - 1);

    // Raw pin level of an untouched key
    localparam logic RELEASED_RAW = BTN_ACTIVE_LOW;

    logic            sync_meta;
    logic            sync_out;
    logic            sample;
    logic            stable;
    logic [DB_W-1:0] db_count;
    channel_state_t  state;
    logic [RP_W-1:0] rep_count;

    // Two-flop synchronizer; resets to the idle pin level so no false press
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= RELEASED_RAW;
            sync_out  <= RELEASED_RAW;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // Normalise polarity so that 1 always means pressed from here on
    assign sample = sync_out ^ BTN_ACTIVE_LOW;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES differing samples in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            stable   <= 1'b0;
            db_count <= '0;
        end else if (sample == stable) begin
            db_count <= '0;
        end else if (db_count == DB_LAST) begin
            stable   <= sample;
            db_count <= '0;
        end else begin
            db_count <= db_count + DB_W'(1);
        end
    end

    // Hold tracker: press pulse, then delayed first repeat, then periodic repeats
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RELEASED;
            rep_count <= '0;
            pulse     <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (!stable) begin
                state     <= ST_RELEASED;
                rep_count <= '0;
            end else begin
                case (state)
                    ST_RELEASED: begin
                        state     <= ST_HELD_DELAY;
                        rep_count <= '0;
                        pulse     <= 1'b1;
                    end
                    ST_HELD_DELAY: begin
                        if (REPEAT_EN && (rep_count == DELAY_LAST)) begin
                            state     <= ST_HELD_REPEAT;
                            rep_count <= '0;
                            pulse     <= 1'b1;
                        end else if (rep_count != DELAY_LAST) begin
                            rep_count <= rep_count + RP_W'(1);
                        end
                    end
                    ST_HELD_REPEAT: begin
                        if (rep_count == RATE_LAST) begin
                            rep_count <= '0;
                            pulse     <= 1'b1;
                        end else begin
                            rep_count <= rep_count + RP_W'(1);
                        end
                    end
                    default: begin
                        state     <= ST_RELEASED;
                        rep_count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel key conditioner for the LockIn UI: three conditioned key
// channels feeding the frequency memory, with an up/down interlock so that
// simultaneous up and down requests cancel instead of fighting.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES,
    parameter bit BTN_ACTIVE_LOW      = DEFAULT_BTN_ACTIVE_LOW
)
(
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic btn_scale_raw,
    output logic btn_up,
    output logic btn_down,
    output logic btn_scale
);

    logic up_pulse;
    logic down_pulse;
    logic scale_pulse;

    button_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
        .BTN_ACTIVE_LOW      (BTN_ACTIVE_LOW),
        .REPEAT_EN           (1'b1)
    ) u_up (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_up_raw),
        .pulse (up_pulse)
    );

    button_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
        .BTN_ACTIVE_LOW      (BTN_ACTIVE_LOW),
        .REPEAT_EN           (1'b1)
    ) u_down (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_down_raw),
        .pulse (down_pulse)
    );

    // Scale steps through ranges, so holding it must not keep cycling
    button_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
        .BTN_ACTIVE_LOW      (BTN_ACTIVE_LOW),
        .REPEAT_EN           (1'b0)
    ) u_scale (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_scale_raw),
        .pulse (scale_pulse)
    );

    // Registered outputs: cancel coincident up/down, never hold a pulse two cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_up    <= 1'b0;
            btn_down  <= 1'b0;
            btn_scale <= 1'b0;
        end else begin
            btn_up    <= up_pulse & ~down_pulse & ~btn_up;
            btn_down  <= down_pulse & ~up_pulse & ~btn_down;
            btn_scale <= scale_pulse & ~btn_scale;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short timing parameters:
// a vector table, hand-written hold/interlock/reset sequences, and a random
// phase compared against an arithmetic model of the key behaviour.
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int DLY  = 16;
    localparam int RATE = 8;
    localparam int NVEC = 75;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_up_raw = 1'b0;
    logic btn_down_raw = 1'b0;
    logic btn_scale_raw = 1'b0;
    logic btn_up;
    logic btn_down;
    logic btn_scale;

    int tests_run = 0;
    int tests_failed = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES     (DEB),
        .REPEAT_DELAY_CYCLES (DLY),
        .REPEAT_RATE_CYCLES  (RATE),
        .BTN_ACTIVE_LOW      (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_up_raw    (btn_up_raw),
        .btn_down_raw  (btn_down_raw),
        .btn_scale_raw (btn_scale_raw),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_scale     (btn_scale)
    );

    always #5 clk = ~clk;

    // Reference model: raw pins reach the filter two samples late; a level is
    // accepted once the last DEB samples all disagree with it; pulses depend only
    // on how many edges have passed since the accepted press.
    logic [1:0]     m_pipe   [3];
    logic [DEB-1:0] m_win    [3];
    logic           m_stable [3];
    longint         m_rise   [3];
    logic           m_pend   [3];
    logic           exp_up = 1'b0;
    logic           exp_dn = 1'b0;
    logic           exp_sc = 1'b0;
    longint         edge_no = 0;

    int up_t[$];
    int dn_t[$];
    int sc_t[$];

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_pipe[c]   = 2'b00;
            m_win[c]    = '0;
            m_stable[c] = 1'b0;
            m_rise[c]   = 0;
            m_pend[c]   = 1'b0;
        end
        exp_up = 1'b0;
        exp_dn = 1'b0;
        exp_sc = 1'b0;
    endtask

    task automatic model_edge();
        logic   raw [3];
        logic   np  [3];
        logic   s;
        longint h;
        raw[0] = btn_up_raw;
        raw[1] = btn_down_raw;
        raw[2] = btn_scale_raw;
        edge_no++;
        if (reset) begin
            model_reset();
            return;
        end
        exp_up = m_pend[0] & ~m_pend[1] & ~exp_up;
        exp_dn = m_pend[1] & ~m_pend[0] & ~exp_dn;
        exp_sc = m_pend[2] & ~exp_sc;
        for (int c = 0; c < 3; c++) begin
            np[c] = 1'b0;
            if (m_stable[c]) begin
                h = edge_no - m_rise[c];
                np[c] = (h == 1) ||
                        (c != 2 && h >= 1 + DLY && ((h - 1 - DLY) % RATE) == 0);
            end
            s = m_pipe[c][1];
            m_pipe[c] = {m_pipe[c][0], raw[c]};
            m_win[c]  = {m_win[c][DEB-2:0], s};
            if (m_win[c] == {DEB{~m_stable[c]}}) begin
                m_stable[c] = ~m_stable[c];
                if (m_stable[c]) begin
                    m_rise[c] = edge_no;
                end
            end
            m_pend[c] = np[c];
        end
    endtask

    // Drive inputs just after an edge, advance one clock, sample 1 ns later
    task automatic apply_stimulus(input logic rst, input logic u, input logic d, input logic s);
        reset         = rst;
        btn_up_raw    = u;
        btn_down_raw  = d;
        btn_scale_raw = s;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_output(input string name, input logic [2:0] act, input logic [2:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: up/down/scale got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        up_t.delete();
        dn_t.delete();
        sc_t.delete();
    endtask

    // Run n cycles with fixed inputs, logging output pulse times from base
    task automatic run_phase(input logic rst, input logic u, input logic d, input logic s,
                             input int n, input int base);
        for (int k = 0; k < n; k++) begin
            apply_stimulus(rst, u, d, s);
            if (btn_up)    up_t.push_back(base + k);
            if (btn_down)  dn_t.push_back(base + k);
            if (btn_scale) sc_t.push_back(base + k);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    typedef struct {
        logic rst;
        logic u;
        logic d;
        logic s;
        logic eu;
        logic ed;
        logic es;
    } vec_t;

    vec_t vecs [NVEC];

    int   exp_rep [7];
    int   seg_len;
    int   odds;
    logic ru;
    logic rd;
    logic rs;
    logic rr;

    initial begin
        model_reset();

        // Table: reset, clean 10-cycle up press, then a 1,1,1,0 down bounce
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].rst = (i < 2);
            vecs[i].u   = (i >= 5 && i < 15);
            vecs[i].d   = (i >= 27 && i < 67) && (((i - 27) % 4) != 3);
            vecs[i].s   = 1'b0;
            vecs[i].eu  = (i == 12);
            vecs[i].ed  = 1'b0;
            vecs[i].es  = 1'b0;
        end
        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].u, vecs[i].d, vecs[i].s);
            check_output($sformatf("vector %0d", i), {btn_up, btn_down, btn_scale},
                         {vecs[i].eu, vecs[i].ed, vecs[i].es});
        end

        // Up held 60 cycles: press pulse at 7, first repeat 16 later, then every 8
        exp_rep = '{7, 23, 31, 39, 47, 55, 63};
        apply_reset();
        run_phase(1'b0, 1'b1, 1'b0, 1'b0, 60, 0);
        run_phase(1'b0, 1'b0, 1'b0, 1'b0, 40, 60);
        check_int("up hold pulse count", up_t.size(), 7);
        for (int i = 0; i < 7; i++) begin
            check_int($sformatf("up hold pulse %0d time", i), q_at(up_t, i), exp_rep[i]);
        end
        check_int("up hold down pulses", dn_t.size(), 0);

        // Scale held 60 cycles: one press pulse only
        apply_reset();
        run_phase(1'b0, 1'b0, 1'b0, 1'b1, 60, 0);
        run_phase(1'b0, 1'b0, 1'b0, 1'b0, 20, 60);
        check_int("scale hold pulse count", sc_t.size(), 1);
        check_int("scale hold pulse time", q_at(sc_t, 0), 7);

        // Up and down together: every coincident pulse cancelled, scale untouched
        apply_reset();
        run_phase(1'b0, 1'b1, 1'b1, 1'b1, 60, 0);
        run_phase(1'b0, 1'b0, 1'b0, 1'b0, 20, 60);
        check_int("interlock up pulses", up_t.size(), 0);
        check_int("interlock down pulses", dn_t.size(), 0);
        check_int("interlock scale pulses", sc_t.size(), 1);

        // Reset 20 cycles into an up hold, key kept pressed throughout
        apply_reset();
        run_phase(1'b0, 1'b1, 1'b0, 1'b0, 20, 0);
        check_int("pre-reset press pulse time", q_at(up_t, 0), 7);
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
            check_output($sformatf("mid-hold reset cycle %0d", k),
                         {btn_up, btn_down, btn_scale}, 3'b000);
        end
        up_t.delete();
        run_phase(1'b0, 1'b1, 1'b0, 1'b0, 20, 0);
        check_int("post-reset pulse count", up_t.size(), 1);
        check_int("post-reset pulse time", q_at(up_t, 0), 7);
        run_phase(1'b0, 1'b0, 1'b0, 1'b0, 12, 20);

        // Random phase: mixes bouncy and steady segments with rare resets
        ru = 1'b0;
        rd = 1'b0;
        rs = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            seg_len = $urandom_range(5, 60);
            odds    = ($urandom_range(0, 2) == 0) ? 3 : 25;
            for (int k = 0; k < seg_len; k++) begin
                rr = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, odds - 1) == 0) ru = ~ru;
                if ($urandom_range(0, odds - 1) == 0) rd = ~rd;
                if ($urandom_range(0, odds - 1) == 0) rs = ~rs;
                apply_stimulus(rr, ru, rd, rs);
                check_output($sformatf("random seg %0d cycle %0d", seg, k),
                             {btn_up, btn_down, btn_scale}, {exp_up, exp_dn, exp_sc});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
